gat_layer_sched: RTL and testbench

Layer-level sequencer that sits between the host register bank and `gat_top_wrapper`. For each GAT layer it asks the host to load the H data, node-info and weight BRAMs, and waits for all three load-done flags. It then waits for the core to finish and drains the new-feature BRAM through port B into a valid/ready output stream. It repeats this for `NUM_LAYERS` layers and then reports completion.

---
 rtl/gat_pkg.sv | 9 +
 rtl/gat_sched_skid_fifo.sv | 39 +++
 rtl/gat_layer_sched.sv | 118 +++++++++++
 tb/tb_gat_layer_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// gat_pkg: shared scheduler state enum and default new-feature buffer geometry
package gat_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_LOAD, WAIT_CORE, DRAIN, NEXT} sched_state_t;
  localparam int DEF_NUM_SUBGRAPHS = 2708;
  localparam int DEF_NUM_FEATURE_OUT = 16;
  localparam int DEF_NEW_FEATURE_DEPTH = DEF_NUM_SUBGRAPHS * DEF_NUM_FEATURE_OUT;
  localparam int DEF_NEW_FEATURE_ADDR_W = $clog2(DEF_NEW_FEATURE_DEPTH);
  localparam int DEF_FEAT_BYTE_ADDR_W = DEF_NEW_FEATURE_ADDR_W + 2;
endpackage

// File: rtl/gat_sched_skid_fifo.sv
// gat_sched_skid_fifo: 2-entry valid/ready buffer that reports its occupancy
module gat_sched_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr, push, pop;
  assign pop = out_valid & out_ready;
  assign push = in_valid & (occ != 2'd2 || pop);
  assign out_valid = occ != 2'd0;
  assign out_data = mem[rd_ptr];
  // storage, pointers and occupancy; the head word stays put until it is popped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= in_data;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/gat_layer_sched.sv
// gat_layer_sched: per-layer load/compute/drain sequencer for gat_top_wrapper; GAT_SCHED_WATCHDOG_EN adds a wait-state watchdog driving err
module gat_layer_sched
  import gat_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int NUM_SUBGRAPHS = DEF_NUM_SUBGRAPHS,
  parameter int NUM_FEATURE_OUT = DEF_NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int TIMEOUT_W = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_LAYERS):0]    layer_idx,
  output logic                           load_req,
  input  logic                           h_data_bram_load_done,
  input  logic                           h_node_info_bram_load_done,
  input  logic                           wgt_bram_load_done,
  output logic                           gat_layer,
  input  logic                           gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0]  feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]   feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]   feat_tdata,
  output logic                           feat_tvalid,
  input  logic                           feat_tready,
  output logic                           feat_tlast,
  output logic                           err
);
  localparam int LW = $clog2(NUM_LAYERS) + 1;
  localparam int AW = NEW_FEATURE_ADDR_W;
  sched_state_t state, state_n;
  logic [AW:0] rd_addr;
  logic [AW-1:0] word_cnt;
  logic [1:0] occ;
  logic [2:0] pending;
  logic in_flight, issue, hs, last_word, last_layer, all_loaded, timeout;
  assign all_loaded = h_data_bram_load_done & h_node_info_bram_load_done & wgt_bram_load_done;
  assign hs = feat_tvalid & feat_tready;
  assign last_word = word_cnt == AW'(NEW_FEATURE_DEPTH - 1);
  assign last_layer = layer_idx == LW'(NUM_LAYERS - 1);
  // words that will still be held or arriving after this cycle's pop; keeps the 2-entry FIFO from overflowing at full rate
  assign pending = {1'b0, occ} + {2'b0, in_flight} - {2'b0, hs};
  assign issue = state == DRAIN && rd_addr < (AW+1)'(NEW_FEATURE_DEPTH) && pending < 3'd2;
  assign busy = state != IDLE;
  assign load_req = state == REQ;
  assign done = state == NEXT && last_layer;
  assign gat_layer = layer_idx[0];
  assign feat_tlast = feat_tvalid & last_word;
  assign feat_bram_addrb = {rd_addr[AW-1:0], 2'b00};
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state logic; the watchdog overrides everything
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? REQ : IDLE;
      REQ:       state_n = WAIT_LOAD;
      WAIT_LOAD: state_n = all_loaded ? WAIT_CORE : WAIT_LOAD;
      WAIT_CORE: state_n = gat_ready ? DRAIN : WAIT_CORE;
      DRAIN:     state_n = (hs && last_word) ? NEXT : DRAIN;
      NEXT:      state_n = last_layer ? IDLE : REQ;
      default:   state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
  end
  // layer index, drain counters and the one-deep BRAM read pipeline
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      layer_idx <= '0;
      rd_addr <= '0;
      word_cnt <= '0;
      in_flight <= 1'b0;
    end else begin
      if (state == IDLE && start) layer_idx <= '0;
      else if (state == NEXT && !last_layer) layer_idx <= layer_idx + LW'(1);
      if (state == WAIT_CORE && gat_ready) begin
        rd_addr <= '0;
        word_cnt <= '0;
      end else begin
        if (issue) rd_addr <= rd_addr + (AW+1)'(1);
        if (hs && !last_word) word_cnt <= word_cnt + AW'(1);
      end
      in_flight <= issue;
    end
  gat_sched_skid_fifo #(.W(NEW_FEATURE_WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(state != DRAIN),
    .in_valid(in_flight),
    .in_data(feat_bram_dout),
    .out_valid(feat_tvalid),
    .out_data(feat_tdata),
    .out_ready(feat_tready),
    .occ(occ)
  );
`ifdef GAT_SCHED_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  assign timeout = (state == WAIT_LOAD || state == WAIT_CORE) && &wd_cnt;
  // residency counter for the wait states; expiry latches err until reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd_cnt <= '0;
      err <= 1'b0;
    end else begin
      wd_cnt <= (state_n != state) ? '0 : (state == WAIT_LOAD || state == WAIT_CORE) ? wd_cnt + TIMEOUT_W'(1) : wd_cnt;
      err <= err | timeout;
    end
`else
  assign timeout = 1'b0;
  assign err = TIMEOUT_W < 1;
`endif
endmodule

// File: tb/tb_gat_layer_sched.sv
// tb_gat_layer_sched: self-checking bench with BRAM/host models and a stream scoreboard
module tb_gat_layer_sched;
  import gat_pkg::*;
  localparam int NL = 2, NS = 2, NF = 4, DEPTH = NS * NF, AW = 3, DW = 32;
  logic clk = 1'b0, rst, start, h_ld, n_ld, w_ld, gat_ready, feat_tready;
  logic busy, done, load_req, gat_layer, feat_tvalid, feat_tlast, err;
  logic [1:0] layer_idx;
  logic [AW+1:0] feat_bram_addrb;
  logic [DW-1:0] feat_bram_dout, feat_tdata;

  gat_layer_sched #(
    .NUM_LAYERS(NL), .NUM_SUBGRAPHS(NS), .NUM_FEATURE_OUT(NF),
    .NEW_FEATURE_WIDTH(DW), .TIMEOUT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .layer_idx(layer_idx), .load_req(load_req),
    .h_data_bram_load_done(h_ld), .h_node_info_bram_load_done(n_ld),
    .wgt_bram_load_done(w_ld), .gat_layer(gat_layer), .gat_ready(gat_ready),
    .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .feat_tdata(feat_tdata), .feat_tvalid(feat_tvalid), .feat_tready(feat_tready),
    .feat_tlast(feat_tlast), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [2:0] flags; bit adv;} ld_vec_t;
  ld_vec_t tbl [8];
  logic [DW-1:0] bram [NL][DEPTH];
  int n_chk = 0, n_pass = 0, cyc = 0, sb_idx = 0, n_req = 0, n_done = 0, nd0 = 0;
  int last_hs_cyc = 0, first_v_cyc = 0, last_v_cyc = 0;
  bit rnd_ready = 1'b0, hold_v = 1'b0;
  logic [DW-1:0] hold_d;

  always @(posedge clk) cyc++;
  always @(posedge clk) feat_bram_dout <= bram[gat_layer][feat_bram_addrb[AW+1:2]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: the stream must be bram[layer][0..DEPTH-1] per layer, in order, tlast on the last word
  always @(negedge clk)
    if (!rst) begin
      if (load_req) begin
        chk("load_req_layer_idx", layer_idx, n_req);
        chk("load_req_gat_layer", gat_layer, n_req % 2);
        n_req++;
      end
      if (feat_tvalid && feat_tready) begin
        if (sb_idx < NL * DEPTH) begin
          chk("tdata", feat_tdata, bram[sb_idx / DEPTH][sb_idx % DEPTH]);
          chk("tlast", feat_tlast, sb_idx % DEPTH == DEPTH - 1);
        end else chk("extra_word", 1, 0);
        if (sb_idx % DEPTH == 0) first_v_cyc = cyc;
        if (sb_idx % DEPTH == DEPTH - 1) begin
          last_v_cyc = cyc;
          last_hs_cyc = cyc;
        end
        sb_idx++;
      end
      if (hold_v) chk("tdata_stable", {feat_tvalid, feat_tdata}, {1'b1, hold_d});
      hold_v = feat_tvalid && !feat_tready;
      hold_d = feat_tdata;
      if (done) begin
        chk("done_after_tlast", cyc, last_hs_cyc + 1);
        n_done++;
      end
    end else hold_v = 1'b0;

  initial begin
    feat_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      feat_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic begin_run();
    n_req = 0;
    sb_idx = 0;
    nd0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_to_load_req", load_req, 1);
  endtask

  task automatic do_layer(input int mode, input bit hold, input bit spulse);
    int p, tgt;
    bit ok;
    logic [1:0] li;
    tgt = sb_idx + DEPTH;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (load_req) begin ok = 1'b1; break; end
      tick();
    end
    chk("load_req_seen", ok, 1);
    if (mode == 0) begin
      tick();
      {h_ld, n_ld, w_ld} = 3'b111;
      tick();
      chk("all_loaded_to_wait_core", dut.state == WAIT_CORE, 1);
    end else if (mode == 1) begin
      for (int k = 1; k <= 13; k++) begin
        tick();
        if (k == 5) h_ld = 1'b1;
        if (k == 9) n_ld = 1'b1;
        if (k == 12) w_ld = 1'b1;
        chk("stagger_wait_core", dut.state == WAIT_CORE, k == 13);
      end
    end else begin
      tick();
      for (int i = 0; i < 8; i++) begin
        {h_ld, n_ld, w_ld} = tbl[i].flags;
        tick();
        chk("flag_table", dut.state == WAIT_CORE, tbl[i].adv);
      end
    end
    if (gat_ready) begin
      tick();
      chk("ready_level_exit", dut.state == DRAIN, 1);
    end else begin
      if (spulse) begin
        li = layer_idx;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_idx", layer_idx, li);
        chk("start_ignored_state", dut.state == WAIT_CORE, 1);
      end
      p = cyc;
      gat_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (feat_tvalid) break;
      end
      chk("ready_to_tvalid", cyc - p, 3);
    end
    {h_ld, n_ld, w_ld} = 3'b000;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (sb_idx >= tgt) break;
    end
    chk("layer_drained", sb_idx, tgt);
    if (!hold) gat_ready = 1'b0;
    if (!rnd_ready) chk("throughput", last_v_cyc - first_v_cyc, DEPTH - 1);
  endtask

  task automatic end_run();
    tick();
    chk("done_count", n_done, nd0 + 1);
    chk("idle_after_done", busy, 0);
    chk("load_req_count", n_req, NL);
    chk("word_count", sb_idx, NL * DEPTH);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_load_req"}, load_req, 0);
    chk({tag, "_gat_layer"}, gat_layer, 0);
    chk({tag, "_tvalid"}, feat_tvalid, 0);
    chk({tag, "_tlast"}, feat_tlast, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_layer_idx"}, layer_idx, 0);
    chk({tag, "_addrb"}, feat_bram_addrb, 0);
    chk({tag, "_tdata"}, feat_tdata, 0);
  endtask

  initial begin
    tbl[0] = '{3'b000, 1'b0};
    tbl[1] = '{3'b100, 1'b0};
    tbl[2] = '{3'b010, 1'b0};
    tbl[3] = '{3'b001, 1'b0};
    tbl[4] = '{3'b110, 1'b0};
    tbl[5] = '{3'b011, 1'b0};
    tbl[6] = '{3'b101, 1'b0};
    tbl[7] = '{3'b111, 1'b1};
    foreach (bram[l, a]) bram[l][a] = $urandom;
    rst = 1'b1;
    start = 1'b0;
    {h_ld, n_ld, w_ld} = 3'b000;
    gat_ready = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    chk("reset_state", dut.state == IDLE, 1);
    rst = 1'b0;
    tick();
    // two layers at full rate, start pulsed while waiting on the core
    rnd_ready = 1'b0;
    begin_run();
    do_layer(0, 1'b0, 1'b1);
    do_layer(0, 1'b0, 1'b0);
    end_run();
    // random back-pressure, staggered load flags, flag combination table
    rnd_ready = 1'b1;
    begin_run();
    do_layer(1, 1'b0, 1'b0);
    do_layer(2, 1'b0, 1'b0);
    end_run();
    // gat_ready held high across both layers
    rnd_ready = 1'b0;
    begin_run();
    do_layer(0, 1'b1, 1'b0);
    do_layer(0, 1'b1, 1'b0);
    gat_ready = 1'b0;
    end_run();
    // reset in the middle of the second layer's drain
    begin_run();
    do_layer(0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (load_req) break;
      tick();
    end
    tick();
    {h_ld, n_ld, w_ld} = 3'b111;
    tick();
    gat_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (sb_idx >= DEPTH + 3) break;
    end
    chk("words_before_reset", sb_idx, DEPTH + 3);
    chk("layer_idx_before_reset", layer_idx, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    tick();
    chk_reset_outputs("reset_next_cycle");
    {h_ld, n_ld, w_ld} = 3'b000;
    gat_ready = 1'b0;
    rst = 1'b0;
    nd0 = n_done;
    repeat (20) tick();
    chk("no_done_after_reset", n_done, nd0);
    chk("idle_after_reset", busy, 0);
`ifdef GAT_SCHED_WATCHDOG_EN
    begin_run();
    tick();
    {h_ld, n_ld, w_ld} = 3'b111;
    tick();
    chk("wd_in_wait_core", dut.state == WAIT_CORE, 1);
    nd0 = n_done;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("wd_err", err, k == 16);
      chk("wd_busy", busy, k != 16);
    end
    {h_ld, n_ld, w_ld} = 3'b000;
    repeat (5) tick();
    chk("wd_err_sticky", err, 1);
    chk("wd_no_done", n_done, nd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
